// File: rtl/wb_stream_pkg.sv
// ---------------------------------------------------------------------------
// wb_stream_pkg
// Shared definitions for the Wishbone-to-stream bridge: stream opcodes,
// controller state and request encodings, and the STATUS register layout.
// No ports; imported by wb_stream_bridge.
// ---------------------------------------------------------------------------
package wb_stream_pkg;

   localparam logic [31:0] OP_LOAD  = 32'h0000_0000;
   localparam logic [31:0] OP_STORE = 32'h0800_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUSH,
      ST_WAIT,
      ST_DRAIN,
      ST_RESP
   } state_e;

   typedef enum logic [1:0] {
      REQ_INSTR_WR,
      REQ_DATA_WR,
      REQ_DATA_RD
   } req_e;

   localparam int STATUS_TIMEOUT_BIT = 31;
   localparam int STATUS_ICNT_LSB    = 8;
   localparam int STATUS_LCNT_LSB    = 0;

   // STATUS sits one word past the last DATA word; the INSTR word is at
   // offset 0 and DATA occupies offsets 4 .. 4*numWords.
   function automatic logic [31:0] statusOffset(input int numWords);
      return 32'(4 * (numWords + 1));
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
// Small synchronous FIFO with a val/rdy read side.
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   push_i, data_i  write request and data (ignored while full_o)
//   full_o          no free entry this cycle
//   val_o, msg_o    head entry valid / head entry
//   rdy_i           consumer ready; pops when val_o && rdy_i
//   count_o         number of occupied entries
// ---------------------------------------------------------------------------
module stream_fifo #(
   parameter int  WIDTH = 32,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             full_o,
   output logic             val_o,
   output logic [WIDTH-1:0] msg_o,
   input  logic             rdy_i,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush;
   logic             doPop;

   // Fullness is judged on the registered count, so a pop in the same
   // cycle does not make room for a push until the following cycle.
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign val_o   = (count_q != '0);
   assign msg_o   = mem_q[rdPtr_q];
   assign count_o = count_q;
   assign doPush  = push_i && !full_o;
   assign doPop   = val_o && rdy_i;

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a
   // power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; an empty FIFO never presents its contents
   // as valid.
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

endmodule

// File: rtl/wb_stream_bridge.sv
// ---------------------------------------------------------------------------
// wb_stream_bridge
// Wishbone classic slave that turns bus accesses into instruction/load
// stream beats and collects store-return beats for reads.
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat_i Wishbone request
//   wbs_ack_o, wbs_err_o         one-cycle completion pulses
//   wbs_dat_o                    registered read data
//   instruction_recv_*           outbound instruction stream (32b)
//   load_recv_*                  outbound load stream {idx, data}
//   store_send_*                 inbound store-return stream
// Address window: BASE -> INSTR (write only), BASE+4.. -> DATA words,
// one word past the last DATA word -> STATUS; anything else errors.
// ---------------------------------------------------------------------------
module wb_stream_bridge
   import wb_stream_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          NUM_WORDS  = 1024,
   parameter int          FIFO_DEPTH = 4,
   parameter int          TIMEOUT    = 255,
   localparam int         IDX_W      = $clog2(NUM_WORDS)
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic              wbs_err_o,
   output logic [31:0]       wbs_dat_o,
   output logic [31:0]       instruction_recv_msg,
   output logic              instruction_recv_val,
   input  logic              instruction_recv_rdy,
   output logic [IDX_W+31:0] load_recv_msg,
   output logic              load_recv_val,
   input  logic              load_recv_rdy,
   input  logic [31:0]       store_send_msg,
   input  logic              store_send_val,
   output logic              store_send_rdy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

   state_e             state_q, state_d;
   req_e               kind_q, kind_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               respErr_q, respErr_d;
   logic [31:0]        dat_q, dat_d;
   logic               timeout_q, timeout_d;

   logic [31:0]        offset;
   logic [29:0]        wordNum;
   logic               isInstr, isData, isStatus;
   logic [IDX_W-1:0]   dataIdx;
   logic [31:0]        statusWord;

   logic               instrPush, instrFull;
   logic [31:0]        instrPushData;
   logic [FCW-1:0]     instrCount;
   logic               loadPush, loadFull;
   logic [IDX_W+31:0]  loadPushData;
   logic [FCW-1:0]     loadCount;

   // Address decode relative to the window base; misaligned offsets match
   // nothing and fall through to the error response.
   assign offset   = wbs_adr_i - BASE_ADDR;
   assign wordNum  = offset[31:2];
   assign isInstr  = (offset == 32'h0);
   assign isData   = (offset[1:0] == 2'b00) && (wordNum >= 30'd1)
                     && (wordNum <= 30'(NUM_WORDS));
   assign isStatus = (offset == statusOffset(NUM_WORDS));
   assign dataIdx  = IDX_W'(wordNum - 30'd1);

   // STATUS layout: sticky timeout on top, FIFO occupancies in the low
   // two bytes.
   always_comb begin
      statusWord = '0;
      statusWord[STATUS_TIMEOUT_BIT]       = timeout_q;
      statusWord[STATUS_ICNT_LSB +: 8]     = 8'(instrCount);
      statusWord[STATUS_LCNT_LSB +: 8]     = 8'(loadCount);
   end

   stream_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_instrFifo (
      .clk_i   (wb_clk_i),
      .rst_ni  (wb_rst_ni),
      .push_i  (instrPush),
      .data_i  (instrPushData),
      .full_o  (instrFull),
      .val_o   (instruction_recv_val),
      .msg_o   (instruction_recv_msg),
      .rdy_i   (instruction_recv_rdy),
      .count_o (instrCount)
   );

   stream_fifo #(.WIDTH(IDX_W+32), .DEPTH(FIFO_DEPTH)) u_loadFifo (
      .clk_i   (wb_clk_i),
      .rst_ni  (wb_rst_ni),
      .push_i  (loadPush),
      .data_i  (loadPushData),
      .full_o  (loadFull),
      .val_o   (load_recv_val),
      .msg_o   (load_recv_msg),
      .rdy_i   (load_recv_rdy),
      .count_o (loadCount)
   );

   // Controller next state. IDLE decodes and latches the request, PUSH
   // waits for FIFO room and pushes (pairs go into both FIFOs in the same
   // cycle so the two streams stay aligned), WAIT collects the store
   // return for a DATA read, DRAIN soaks up a return whose master has
   // gone away, and RESP presents the completion for exactly one cycle.
   // The WAIT counter runs 0..TIMEOUT, so store_send_rdy is high for
   // TIMEOUT+1 cycles before the error completion is issued.
   always_comb begin
      state_d       = state_q;
      kind_d        = kind_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      respErr_d     = respErr_q;
      dat_d         = dat_q;
      timeout_d     = timeout_q;
      instrPush     = 1'b0;
      instrPushData = wbs_dat_i;
      loadPush      = 1'b0;
      loadPushData  = {idx_q, 32'h0};
      store_send_rdy = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               respErr_d = 1'b0;
               if (wbs_we_i && (wbs_sel_i != 4'hF)) begin
                  respErr_d = 1'b1;
                  state_d   = ST_RESP;
               end else if (isInstr && wbs_we_i) begin
                  kind_d  = REQ_INSTR_WR;
                  state_d = ST_PUSH;
               end else if (isData) begin
                  kind_d  = wbs_we_i ? REQ_DATA_WR : REQ_DATA_RD;
                  idx_d   = dataIdx;
                  state_d = ST_PUSH;
               end else if (isStatus) begin
                  if (wbs_we_i) begin
                     if (wbs_dat_i[STATUS_TIMEOUT_BIT]) begin
                        timeout_d = 1'b0;
                     end
                  end else begin
                     dat_d = statusWord;
                  end
                  state_d = ST_RESP;
               end else begin
                  respErr_d = 1'b1;
                  state_d   = ST_RESP;
               end
            end
         end

         ST_PUSH: begin
            if (!wbs_cyc_i) begin
               state_d = ST_IDLE;
            end else if (kind_q == REQ_INSTR_WR) begin
               if (!instrFull) begin
                  instrPush     = 1'b1;
                  instrPushData = wbs_dat_i;
                  state_d       = ST_RESP;
               end
            end else if (!instrFull && !loadFull) begin
               instrPush = 1'b1;
               loadPush  = 1'b1;
               if (kind_q == REQ_DATA_WR) begin
                  instrPushData = OP_LOAD;
                  loadPushData  = {idx_q, wbs_dat_i};
                  state_d       = ST_RESP;
               end else begin
                  instrPushData = OP_STORE;
                  loadPushData  = {idx_q, 32'h0};
                  cnt_d         = '0;
                  state_d       = ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            store_send_rdy = 1'b1;
            if (store_send_val) begin
               if (wbs_cyc_i) begin
                  dat_d     = store_send_msg;
                  respErr_d = 1'b0;
                  state_d   = ST_RESP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (!wbs_cyc_i) begin
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               dat_d     = 32'h0;
               timeout_d = 1'b1;
               respErr_d = 1'b1;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DRAIN: begin
            store_send_rdy = 1'b1;
            if (store_send_val || (cnt_q == CNT_W'(TIMEOUT))) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller registers; reset abandons any transaction in flight.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= ST_IDLE;
         kind_q    <= REQ_INSTR_WR;
         idx_q     <= '0;
         cnt_q     <= '0;
         respErr_q <= 1'b0;
         dat_q     <= 32'h0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         respErr_q <= respErr_d;
         dat_q     <= dat_d;
         timeout_q <= timeout_d;
      end
   end

   // Completions come straight from registered state, one cycle in RESP.
   assign wbs_ack_o = (state_q == ST_RESP) && !respErr_q;
   assign wbs_err_o = (state_q == ST_RESP) && respErr_q;
   assign wbs_dat_o = dat_q;

endmodule
